// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared fetch-stage encodings, constants and FSM state type
package fetch_pc_unit_pkg;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;
  localparam logic [1:0] PC_ZERO   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - selects the next program counter from the EX pcSel code
module next_pc_mux
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] next_pc
);

  // JALR targets have bit 0 cleared before they become the PC
  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      PC_BRANCH: next_pc = branch_target;
      PC_JALR:   next_pc = jalr_target & ~XLEN'(1);
      PC_ZERO:   next_pc = '0;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF stage: PC ownership, single-outstanding imem fetch, IF/ID register
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pcSel,
  input  logic [XLEN-1:0] branchTarget,
  input  logic [XLEN-1:0] jalrTarget,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic [31:0]     ifid_instr
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_plus4, mux_pc, fetch_pc, hold_pc;
  logic [31:0]     hold_instr;
  logic            kill, hold_valid;
  logic            redirect, deliver, issue;

  assign redirect  = (pcSel != PC_PLUS4);
  assign pc_plus4  = pc + XLEN'(4);
  assign imem_addr = {pc[XLEN-1:2], 2'b00};
  assign issue     = imem_req && imem_gnt;

  next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
    .sel           (pcSel),
    .pc_plus4      (pc_plus4),
    .branch_target (branchTarget),
    .jalr_target   (jalrTarget),
    .next_pc       (mux_pc)
  );

  // Request/next-state logic; a redirect suppresses any request this cycle so
  // the wrong path is never granted, and the hold buffer is always empty in S_WAIT
  always_comb begin
    imem_req   = 1'b0;
    deliver    = 1'b0;
    state_next = state;
    case (state)
      S_REQ: begin
        imem_req = !hold_valid && !redirect;
        if (imem_req && imem_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          // remain waiting for the response that is about to be killed
          if (imem_rvalid) state_next = S_REQ;
        end else if (imem_rvalid) begin
          deliver    = !kill;
          // a killed response leaves the hold buffer empty; a delivered one
          // only leaves it empty when it goes straight into IF/ID
          imem_req   = kill || !stall;
          state_next = (imem_req && imem_gnt) ? S_WAIT : S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
    imem_req = imem_req && rst_n;
  end

  // FSM state, program counter, address of the outstanding fetch and kill flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      fetch_pc <= '0;
      kill     <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect || issue) pc <= mux_pc;
      if (issue) fetch_pc <= pc;
      if (state == S_WAIT && imem_rvalid) kill <= 1'b0;
      else if (state == S_WAIT && redirect) kill <= 1'b1;
    end
  end

  // One-entry hold buffer catching a response that arrives while IF/ID is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
    end else if (redirect) begin
      hold_valid <= 1'b0;
    end else if (deliver && stall) begin
      hold_valid <= 1'b1;
      hold_pc    <= fetch_pc;
      hold_instr <= imem_rdata;
    end else if (!stall) begin
      hold_valid <= 1'b0;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, else hold buffer > response > bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      ifid_instr <= NOP_INSTR;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (hold_valid) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= hold_pc;
        ifid_pc4   <= hold_pc + XLEN'(4);
        ifid_instr <= hold_instr;
      end else if (deliver) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= fetch_pc;
        ifid_pc4   <= fetch_pc + XLEN'(4);
        ifid_instr <= imem_rdata;
      end else begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pcSel = 2'b00;
  logic [31:0] branchTarget = '0, jalrTarget = '0;
  logic        stall = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

  int checks = 0;
  int errors = 0;

  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  int          gnt_pct = 100;
  logic        last_req;
  logic [31:0] last_addr;

  fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcSel        (pcSel),
    .branchTarget (branchTarget),
    .jalrTarget   (jalrTarget),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc4     (ifid_pc4),
    .ifid_instr   (ifid_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'd3) ^ 32'hC0DE_0001;
  endfunction

  // One clock cycle: memory responds on the falling edge, grants are sampled
  // before the rising edge, outputs are observed 1 time unit after it.
  task automatic step();
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(mem_addr);
        mem_busy    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    #1;
    last_req  = imem_req;
    last_addr = imem_addr;
    if (imem_req && imem_gnt) begin
      checks++; if (mem_busy) begin errors++; $display("FAIL one_outstanding: request 0x%h granted while 0x%h pending", imem_addr, mem_addr); end
      checks++; if (imem_addr[1:0] !== 2'b00) begin errors++; $display("FAIL addr_align: got 0x%h want low bits 00", imem_addr); end
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = mem_lat - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; pcSel = 2'b00; stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    mem_busy = 1'b0; mem_lat = 1; gnt_pct = 100;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pcSel = 2'b00; stall = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h want 0/0", ifid_pc, ifid_pc4); end
    checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", ifid_instr, NOP); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    apply_reset();
    step();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL seq_first_bubble: got %b want 0", ifid_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got v=%b pc=%h want v=1 pc=%h", i, ifid_valid, ifid_pc, 32'(4 * i)); end
      checks++; if (ifid_pc4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_pc4_%0d: got %h want %h", i, ifid_pc4, 32'(4 * i + 4)); end
      checks++; if (ifid_instr !== word_at(32'(4 * i))) begin errors++; $display("FAIL seq_instr%0d: got %h want %h", i, ifid_instr, word_at(32'(4 * i))); end
    end
  endtask

  task automatic test_branch();
    apply_reset();
    repeat (4) step();
    pcSel = 2'b01; branchTarget = 32'h100;
    step();
    pcSel = 2'b00;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin errors++; $display("FAIL br_flush: got v=%b instr=%h want v=0 instr=%h", ifid_valid, ifid_instr, NOP); end
    step();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h100) begin errors++; $display("FAIL br_addr: got req=%b addr=%h want req=1 addr=00000100", last_req, last_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_instr !== word_at(32'h100)) begin errors++; $display("FAIL br_ifid: got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=%h", ifid_valid, ifid_pc, ifid_instr, word_at(32'h100)); end
  endtask

  task automatic test_jalr();
    apply_reset();
    repeat (3) step();
    pcSel = 2'b10; jalrTarget = 32'h203;
    step();
    pcSel = 2'b00;
    step();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h200) begin errors++; $display("FAIL jalr_addr: got req=%b addr=%h want req=1 addr=00000200", last_req, last_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== word_at(32'h200)) begin errors++; $display("FAIL jalr_ifid: got v=%b instr=%h want v=1 instr=%h", ifid_valid, ifid_instr, word_at(32'h200)); end
  endtask

  task automatic test_zero();
    apply_reset();
    repeat (2) step();
    pcSel = 2'b01; branchTarget = 32'h80;
    step();
    pcSel = 2'b00;
    repeat (2) step();
    checks++; if (ifid_pc !== 32'h80) begin errors++; $display("FAIL zero_setup: got pc=%h want 00000080", ifid_pc); end
    pcSel = 2'b11;
    step();
    pcSel = 2'b00;
    step();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h0) begin errors++; $display("FAIL zero_addr: got req=%b addr=%h want req=1 addr=00000000", last_req, last_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0) begin errors++; $display("FAIL zero_ifid: got v=%b pc=%h want v=1 pc=00000000", ifid_valid, ifid_pc); end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (3) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h want v=1 pc=00000004", i, ifid_valid, ifid_pc); end
      checks++; if (last_req !== 1'b0) begin errors++; $display("FAIL stall_noreq%0d: got req=%b want 0", i, last_req); end
    end
    stall = 1'b0;
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_instr !== word_at(32'h8)) begin errors++; $display("FAIL stall_release: got v=%b pc=%h instr=%h want v=1 pc=00000008 instr=%h", ifid_valid, ifid_pc, ifid_instr, word_at(32'h8)); end
    checks++; if (last_req !== 1'b0) begin errors++; $display("FAIL stall_release_req: got req=%b want 0", last_req); end
    step();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'hC) begin errors++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=0000000c", last_req, last_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'hC) begin errors++; $display("FAIL stall_next: got v=%b pc=%h want v=1 pc=0000000c", ifid_valid, ifid_pc); end
  endtask

  task automatic test_kill();
    apply_reset();
    mem_lat = 3;
    step();
    pcSel = 2'b01; branchTarget = 32'h40;
    step();
    pcSel = 2'b00;
    checks++; if (last_req !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL kill_redirect: got req=%b v=%b want 0/0", last_req, ifid_valid); end
    step();
    checks++; if (last_req !== 1'b0) begin errors++; $display("FAIL kill_wait: got req=%b want 0", last_req); end
    step();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h40) begin errors++; $display("FAIL kill_reissue: got req=%b addr=%h want req=1 addr=00000040", last_req, last_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL kill_drop: got v=%b want 0", ifid_valid); end
    repeat (2) step();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL kill_gap: got v=%b want 0", ifid_valid); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40) begin errors++; $display("FAIL kill_target: got v=%b pc=%h want v=1 pc=00000040", ifid_valid, ifid_pc); end
    mem_lat = 1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (3) step();
    mem_lat = 3;
    repeat (2) step();
    rst_n = 1'b0;
    #2;
    checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0) begin errors++; $display("FAIL midrst_ifid: got v=%b pc=%h pc4=%h want 0/0/0", ifid_valid, ifid_pc, ifid_pc4); end
    checks++; if (ifid_instr !== NOP || imem_req !== 1'b0) begin errors++; $display("FAIL midrst_out: got instr=%h req=%b want %h/0", ifid_instr, imem_req, NOP); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    gnt_pct = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d: got v=%b want 0", i, ifid_valid); end
    end
    gnt_pct = 100; mem_lat = 1;
    repeat (2) step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== word_at(32'h0)) begin errors++; $display("FAIL midrst_restart: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=%h", ifid_valid, ifid_pc, ifid_instr, word_at(32'h0)); end
  endtask

  // Architectural-order model: every live IF/ID instruction must be the next
  // one in program order, which restarts at the latest redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, prev_instr, tgt;
    logic [1:0]  sel;
    logic        stl, prev_valid;
    int          delivered;
    apply_reset();
    gnt_pct = 70;
    exp_pc = 32'h0;
    delivered = 0;
    for (int n = 0; n < 3000; n++) begin
      sel = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      stl = ($urandom_range(0, 3) == 0);
      branchTarget = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      jalrTarget   = ($urandom() & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
      pcSel = sel; stall = stl;
      mem_lat = $urandom_range(1, 3);
      prev_valid = ifid_valid; prev_pc = ifid_pc; prev_instr = ifid_instr;
      step();
      if (sel != 2'b00) begin
        tgt = (sel == 2'b01) ? branchTarget : (sel == 2'b10) ? (jalrTarget & 32'hFFFF_FFFE) : 32'h0;
        exp_pc = tgt;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin errors++; $display("FAIL rnd_flush@%0d: got v=%b instr=%h want v=0 instr=%h", n, ifid_valid, ifid_instr, NOP); end
      end else if (stl) begin
        checks++; if (ifid_valid !== prev_valid || ifid_instr !== prev_instr || (prev_valid && ifid_pc !== prev_pc)) begin errors++; $display("FAIL rnd_stall@%0d: got v=%b pc=%h instr=%h want v=%b pc=%h instr=%h", n, ifid_valid, ifid_pc, ifid_instr, prev_valid, prev_pc, prev_instr); end
      end else if (ifid_valid) begin
        checks++; if (ifid_pc !== exp_pc || ifid_pc4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_order@%0d: got pc=%h pc4=%h want pc=%h pc4=%h", n, ifid_pc, ifid_pc4, exp_pc, exp_pc + 32'd4); end
        checks++; if (ifid_instr !== word_at(exp_pc)) begin errors++; $display("FAIL rnd_instr@%0d: got %h want %h", n, ifid_instr, word_at(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL rnd_bubble@%0d: got %h want %h", n, ifid_instr, NOP); end
      end
    end
    pcSel = 2'b00; stall = 1'b0;
    checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want at least 200", delivered); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_zero();
    test_stall();
    test_kill();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
